pcc_arbiter_np: RTL and testbench
=================================

PCC_ARBITER_NP -- requirements
Module: pcc_arbiter_np

Interface
REQ-001 The module SHALL have parameter PORTS, default 5, giving the number of input ports (legal range 2..16).
REQ-002 The module SHALL have parameter OUT_PORTS, default 5, giving the number of output ports (legal range 2..16).
REQ-003 The module SHALL have parameter PTRW, default 3, giving the round-robin pointer width; it SHALL be at least clog2(PORTS).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port req_i, input, PORTS bits: connection request, one bit per input port.
REQ-007 The module SHALL have port dest_i, input, PORTS*OUT_PORTS bits: per-input one-hot destination; slice i is [i*OUT_PORTS +: OUT_PORTS].
REQ-008 The module SHALL have port stb_i, input, PORTS bits: per-input strobe; high holds an established connection.
REQ-009 The module SHALL have port fail_i, input, OUT_PORTS bits: per-output fail indication; tears down that output's connection.
REQ-010 The module SHALL have port cancel_i, input, OUT_PORTS bits: per-output cancel indication; tears down that output's connection.
REQ-011 The module SHALL have port grant_o, output, PORTS bits: one-cycle grant pulse, registered.
REQ-012 The module SHALL have port deny_o, output, PORTS bits: one-cycle deny pulse, registered.
REQ-013 The module SHALL have port connections_o, output, PORTS*OUT_PORTS bits: bit [i*OUT_PORTS+o] is set while input i is connected to output o; registered.
REQ-014 The module SHALL have port occupied_o, output, OUT_PORTS bits: occupied_o[o] is the OR of all connections_o bits for output o.

Function
REQ-015 Each input SHALL have a two-state FSM, IDLE or CONN; an input is CONN exactly when its connections_o slice is non-zero.
REQ-016 Input i SHALL be eligible in a cycle when req_i[i]=1 and input i is IDLE.
REQ-017 At most one eligible input SHALL be serviced per cycle: the first eligible index found scanning upward from rr_ptr, wrapping modulo PORTS.
REQ-018 For the serviced input i, a grant SHALL be issued when dest_i slice i is exactly one-hot, the destination index o is not equal to i, and occupied_o[o]=0 as registered at the start of the cycle.
REQ-019 For the serviced input i, a deny SHALL be issued in every other case: zero destination, multi-hot destination, U-turn (o equal to i), or destination already occupied.
REQ-020 On grant, at the next edge: grant_o[i]=1, connection bit (i,o) set, input i moves to CONN.
REQ-021 On deny, at the next edge: deny_o[i]=1 and input i stays IDLE.
REQ-022 grant_o and deny_o SHALL be high for exactly one cycle, SHALL never be high together, and SHALL be one-hot or zero across ports.
REQ-023 Latency from a req_i sample to grant_o or deny_o SHALL be 1 clock.
REQ-024 rr_ptr SHALL become (i+1) mod PORTS after any grant or deny of input i, and SHALL hold when no input is serviced.
REQ-025 A denied input still holding req_i=1 SHALL be re-arbitrated in later cycles with no minimum back-off.
REQ-026 A CONN input i connected to output o SHALL return to IDLE at the next edge when stb_i[i]=0, fail_i[o]=1 or cancel_i[o]=1; its connection bit clears and it is unaffected by req_i meanwhile.
REQ-027 A release and a new request for the same output in the same cycle: the output SHALL be treated as occupied for that cycle (deny), and SHALL be free for arbitration one cycle later.
REQ-028 Multiple releases in the same cycle on different outputs SHALL all take effect at the same edge.
REQ-029 Each output SHALL have at most one connected input and each input at most one output, at all times.
REQ-030 fail_i and cancel_i on an output with no connection SHALL have no effect.

Reset
REQ-031 While reset=1, grant_o, deny_o, connections_o and occupied_o SHALL all be 0, all inputs SHALL be IDLE, and rr_ptr SHALL be 0, asynchronously.
REQ-032 A reset asserted mid-connection SHALL drop all connections; the first arbitration after deassertion SHALL start at index 0.

Verification
REQ-033 Grant: PORTS=5, reset released, req_i=00010, dest slice1=00100, stb_i[1]=1 -> next cycle grant_o=00010, connections_o bit (1,2)=1, occupied_o=00100.
REQ-034 Contention: inputs 0 and 3 request output 4 in the same cycle with rr_ptr=0 -> input 0 granted; input 3 denied the cycle after; rr_ptr=4.
REQ-035 Round-robin: inputs 0..4 each request a distinct free output continuously -> grants in order 0,1,2,3,4, one per cycle.
REQ-036 Release: drop stb_i[1] while (1,2) is connected, with input 0 requesting output 2 in the same cycle -> input 0 denied; (1,2) clears; input 0 granted on its retry the following cycle.
REQ-037 Illegal destination: destination 00000, 00110, or U-turn (input 2 to output 2) -> deny_o pulse; no change to connections_o.
REQ-038 Teardown and reset: fail_i[2]=1 while (1,2) is connected -> connection clears next edge; reset pulsed with 3 connections active -> all outputs 0 immediately, rr_ptr=0.

Source files
------------

// File: rtl/pcc_arbiter_np.sv
`default_nettype none
// ============================================================================
//  Module      : pcc_arbiter_np
//  Description : Round-robin crossbar connection arbiter. Services one
//                requesting idle input per cycle and holds its connection
//                until it is released by strobe, fail or cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcc_arbiter_np #(
    parameter int PORTS     = 5,
    parameter int OUT_PORTS = 5,
    parameter int PTRW      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PORTS-1:0]             req_i,
    input  logic [PORTS*OUT_PORTS-1:0]   dest_i,
    input  logic [PORTS-1:0]             stb_i,
    input  logic [OUT_PORTS-1:0]         fail_i,
    input  logic [OUT_PORTS-1:0]         cancel_i,
    output logic [PORTS-1:0]             grant_o,
    output logic [PORTS-1:0]             deny_o,
    output logic [PORTS*OUT_PORTS-1:0]   connections_o,
    output logic [OUT_PORTS-1:0]         occupied_o
);

    localparam logic [PTRW-1:0] c_last_port = PTRW'(PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONN = 1'b1
    } state_t;

    state_t                       r_state     [PORTS];
    state_t                       w_state_nxt [PORTS];
    logic [PORTS*OUT_PORTS-1:0]   r_conn;
    logic [PORTS*OUT_PORTS-1:0]   w_conn_nxt;
    logic [PORTS-1:0]             r_grant;
    logic [PORTS-1:0]             r_deny;
    logic [PORTS-1:0]             w_grant_nxt;
    logic [PORTS-1:0]             w_deny_nxt;
    logic [PTRW-1:0]              r_ptr;
    logic [PTRW-1:0]              w_ptr_nxt;
    logic [PORTS-1:0]             w_elig;
    logic [PORTS-1:0]             w_release;
    logic [OUT_PORTS-1:0]         w_occupied;
    logic                         w_sel_valid;
    logic [PTRW-1:0]              w_sel;
    int                           w_idx;
    logic [OUT_PORTS-1:0]         w_sel_dest;
    logic                         w_uturn;
    logic                         w_sel_ok;

    // A connected input drops when its strobe falls or its output reports fail/cancel.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_in
        assign w_elig[gi]    = req_i[gi] && (r_state[gi] == ST_IDLE);
        assign w_release[gi] = (r_state[gi] == ST_CONN) &&
                               (!stb_i[gi] ||
                                (|(r_conn[gi*OUT_PORTS +: OUT_PORTS] & (fail_i | cancel_i))));
    end

    always_comb begin
        w_occupied = '0;
        for (int i = 0; i < PORTS; i++) begin
            w_occupied = w_occupied | r_conn[i*OUT_PORTS +: OUT_PORTS];
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        w_idx       = 0;
        for (int k = 0; k < PORTS; k++) begin
            w_idx = (int'(r_ptr) + k) % PORTS;
            if (!w_sel_valid && w_elig[w_idx]) begin
                w_sel_valid = 1'b1;
                w_sel       = PTRW'(w_idx);
            end
        end
    end

    // Occupancy is the registered view, so a same-cycle release still blocks.
    always_comb begin
        w_sel_dest = dest_i[int'(w_sel)*OUT_PORTS +: OUT_PORTS];
        w_uturn    = 1'b0;
        for (int o = 0; o < OUT_PORTS; o++) begin
            if (w_sel_dest[o] && (o == int'(w_sel))) begin
                w_uturn = 1'b1;
            end
        end
        w_sel_ok = $onehot(w_sel_dest) && !w_uturn &&
                   ((w_sel_dest & w_occupied) == '0);
    end

    always_comb begin
        w_conn_nxt  = r_conn;
        w_grant_nxt = '0;
        w_deny_nxt  = '0;
        w_ptr_nxt   = r_ptr;
        for (int i = 0; i < PORTS; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_release[i]) begin
                w_state_nxt[i]                    = ST_IDLE;
                w_conn_nxt[i*OUT_PORTS +: OUT_PORTS] = '0;
            end
        end
        if (w_sel_valid) begin
            w_ptr_nxt = (w_sel == c_last_port) ? '0 : w_sel + 1'b1;
            if (w_sel_ok) begin
                w_grant_nxt[w_sel] = 1'b1;
                w_state_nxt[w_sel] = ST_CONN;
                w_conn_nxt[int'(w_sel)*OUT_PORTS +: OUT_PORTS] = w_sel_dest;
            end else begin
                w_deny_nxt[w_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PORTS; i++) begin
                r_state[i] <= ST_IDLE;
            end
            r_conn  <= '0;
            r_grant <= '0;
            r_deny  <= '0;
            r_ptr   <= '0;
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_conn  <= w_conn_nxt;
            r_grant <= w_grant_nxt;
            r_deny  <= w_deny_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant_o       = r_grant;
    assign deny_o        = r_deny;
    assign connections_o = r_conn;
    assign occupied_o    = w_occupied;

endmodule
`default_nettype wire

// File: tb/tb_pcc_arbiter_np.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcc_arbiter_np
//  Description : Self-checking bench for pcc_arbiter_np: directed vector
//                table, reset sequence, then randomized traffic vs a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcc_arbiter_np;

    localparam int P = 5;
    localparam int Q = 5;
    localparam int W = P * Q;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] req_i;
    logic [W-1:0] dest_i;
    logic [P-1:0] stb_i;
    logic [Q-1:0] fail_i;
    logic [Q-1:0] cancel_i;
    logic [P-1:0] grant_o;
    logic [P-1:0] deny_o;
    logic [W-1:0] connections_o;
    logic [Q-1:0] occupied_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: output index per input, -1 when idle.
    int           m_conn [P];
    int           m_ptr;
    logic [P-1:0] m_grant;
    logic [P-1:0] m_deny;

    pcc_arbiter_np #(
        .PORTS    (P),
        .OUT_PORTS(Q),
        .PTRW     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .dest_i       (dest_i),
        .stb_i        (stb_i),
        .fail_i       (fail_i),
        .cancel_i     (cancel_i),
        .grant_o      (grant_o),
        .deny_o       (deny_o),
        .connections_o(connections_o),
        .occupied_o   (occupied_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0] req;
        logic [W-1:0] dest;
        logic [P-1:0] stb;
        logic [Q-1:0] fail;
        logic [Q-1:0] cancel;
        logic [P-1:0] grant;
        logic [P-1:0] deny;
        logic [W-1:0] conn;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [P-1:0] req, input logic [W-1:0] dest,
                                input logic [P-1:0] stb, input logic [Q-1:0] fail,
                                input logic [Q-1:0] cancel, input logic [P-1:0] grant,
                                input logic [P-1:0] deny, input logic [W-1:0] conn);
        vec_t v;
        v.req = req; v.dest = dest; v.stb = stb; v.fail = fail; v.cancel = cancel;
        v.grant = grant; v.deny = deny; v.conn = conn;
        return v;
    endfunction

    function automatic logic [W-1:0] sl(input int i, input logic [Q-1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[i*Q +: Q] = v;
        return r;
    endfunction

    function automatic logic [Q-1:0] occ_of(input logic [W-1:0] c);
        logic [Q-1:0] r;
        r = '0;
        for (int i = 0; i < P; i++) r = r | c[i*Q +: Q];
        return r;
    endfunction

    function automatic logic [W-1:0] model_conn();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < P; i++) if (m_conn[i] >= 0) r[i*Q + m_conn[i]] = 1'b1;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < P; i++) m_conn[i] = -1;
        m_ptr   = 0;
        m_grant = '0;
        m_deny  = '0;
    endfunction

    function automatic void model_step(input logic [P-1:0] req, input logic [W-1:0] dest,
                                       input logic [P-1:0] stb, input logic [Q-1:0] fail,
                                       input logic [Q-1:0] cancel);
        int           nxt  [P];
        bit           busy [Q];
        logic [Q-1:0] d;
        int           o;
        int           idx;
        for (int b = 0; b < Q; b++) busy[b] = 1'b0;
        for (int i = 0; i < P; i++) begin
            nxt[i] = m_conn[i];
            if (m_conn[i] >= 0) begin
                busy[m_conn[i]] = 1'b1;
                if (!stb[i] || fail[m_conn[i]] || cancel[m_conn[i]]) nxt[i] = -1;
            end
        end
        m_grant = '0;
        m_deny  = '0;
        for (int k = 0; k < P; k++) begin
            idx = (m_ptr + k) % P;
            if (req[idx] && m_conn[idx] < 0) begin
                d = dest[idx*Q +: Q];
                o = -1;
                for (int b = 0; b < Q; b++) if (d[b]) o = b;
                if ($countones(d) == 1 && o != idx && !busy[o]) begin
                    m_grant[idx] = 1'b1;
                    nxt[idx]     = o;
                end else begin
                    m_deny[idx] = 1'b1;
                end
                m_ptr = (idx + 1) % P;
                break;
            end
        end
        for (int i = 0; i < P; i++) m_conn[i] = nxt[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [P-1:0] req, input logic [W-1:0] dest,
                         input logic [P-1:0] stb, input logic [Q-1:0] fail,
                         input logic [Q-1:0] cancel);
        req_i = req; dest_i = dest; stb_i = stb; fail_i = fail; cancel_i = cancel;
        model_step(req, dest, stb, fail, cancel);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " grant"}, 32'(grant_o), 32'(m_grant));
        check({tag, " deny"},  32'(deny_o),  32'(m_deny));
        check({tag, " conn"},  32'(connections_o), 32'(model_conn()));
        check({tag, " occ"},   32'(occupied_o), 32'(occ_of(model_conn())));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rr;
        logic [P-1:0] r_req;
        logic [P-1:0] r_stb;
        logic [W-1:0] r_dest;
        logic [Q-1:0] r_fail;
        logic [Q-1:0] r_cancel;

        rr = sl(0, 5'b00010) | sl(1, 5'b00100) | sl(2, 5'b01000) |
             sl(3, 5'b10000) | sl(4, 5'b00001);

        tbl[0]  = mk(5'b01001, sl(0, 5'b10000) | sl(3, 5'b10000), 5'b11111, 0, 0, 5'b00001, 0, 25'h10);
        tbl[1]  = mk(5'b01001, sl(0, 5'b10000) | sl(3, 5'b10000), 5'b11111, 0, 0, 0, 5'b01000, 25'h10);
        tbl[2]  = mk(5'b00000, '0, 5'b11110, 0, 0, 0, 0, 25'h0);
        tbl[3]  = mk(5'b00010, sl(1, 5'b00100), 5'b11111, 0, 0, 5'b00010, 0, 25'h80);
        tbl[4]  = mk(5'b00001, sl(0, 5'b00100), 5'b11101, 0, 0, 0, 5'b00001, 25'h0);
        tbl[5]  = mk(5'b00001, sl(0, 5'b00100), 5'b11111, 0, 0, 5'b00001, 0, 25'h4);
        tbl[6]  = mk(5'b00100, '0, 5'b11110, 0, 0, 0, 5'b00100, 25'h0);
        tbl[7]  = mk(5'b00100, sl(2, 5'b00110), 5'b11111, 0, 0, 0, 5'b00100, 25'h0);
        tbl[8]  = mk(5'b10000, sl(4, 5'b10000), 5'b11111, 0, 0, 0, 5'b10000, 25'h0);
        tbl[9]  = mk(5'b11111, rr, 5'b11111, 0, 0, 5'b00001, 0, 25'h2);
        tbl[10] = mk(5'b11111, rr, 5'b11111, 0, 0, 5'b00010, 0, 25'h82);
        tbl[11] = mk(5'b11111, rr, 5'b11111, 0, 0, 5'b00100, 0, 25'h2082);
        tbl[12] = mk(5'b11111, rr, 5'b11111, 0, 0, 5'b01000, 0, 25'h82082);
        tbl[13] = mk(5'b11111, rr, 5'b11111, 0, 0, 5'b10000, 0, 25'h182082);
        tbl[14] = mk(5'b11111, rr, 5'b11111, 0, 0, 0, 0, 25'h182082);
        tbl[15] = mk(5'b00000, '0, 5'b11111, 5'b00100, 0, 0, 0, 25'h182002);
        tbl[16] = mk(5'b00000, '0, 5'b11111, 5'b00100, 5'b00011, 0, 0, 25'h82000);
        tbl[17] = mk(5'b00000, '0, 5'b11111, 0, 0, 0, 0, 25'h82000);

        reset = 1'b1;
        req_i = '0; dest_i = '0; stb_i = '0; fail_i = '0; cancel_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset grant", 32'(grant_o), 32'h0);
        check("reset deny",  32'(deny_o),  32'h0);
        check("reset conn",  32'(connections_o), 32'h0);
        check("reset occ",   32'(occupied_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 18; v++) begin
            drive(tbl[v].req, tbl[v].dest, tbl[v].stb, tbl[v].fail, tbl[v].cancel);
            check($sformatf("vec%0d grant", v), 32'(grant_o), 32'(tbl[v].grant));
            check($sformatf("vec%0d deny", v),  32'(deny_o),  32'(tbl[v].deny));
            check($sformatf("vec%0d conn", v),  32'(connections_o), 32'(tbl[v].conn));
            check($sformatf("vec%0d occ", v),   32'(occupied_o), 32'(occ_of(tbl[v].conn)));
        end

        // Third connection, then an asynchronous reset in mid-cycle.
        drive(5'b00010, sl(1, 5'b00100), 5'b11111, 0, 0);
        check("three conns grant", 32'(grant_o), 32'h2);
        check("three conns conn",  32'(connections_o), 32'h82080);
        #2;
        reset = 1'b1;
        #1;
        check("async reset conn",  32'(connections_o), 32'h0);
        check("async reset occ",   32'(occupied_o), 32'h0);
        check("async reset grant", 32'(grant_o), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(5'b10001, sl(0, 5'b00010) | sl(4, 5'b00001), 5'b11111, 0, 0);
        check("post reset first grant", 32'(grant_o), 32'h1);
        check("post reset first conn",  32'(connections_o), 32'h2);
        drive(5'b10001, sl(0, 5'b00010) | sl(4, 5'b00001), 5'b11111, 0, 0);
        check("post reset second grant", 32'(grant_o), 32'h10);
        check("post reset second conn",  32'(connections_o), 32'h100002);

        for (int c = 0; c < 3000; c++) begin
            r_req    = P'($urandom_range(0, 31));
            r_dest   = '0;
            r_stb    = '0;
            r_fail   = '0;
            r_cancel = '0;
            for (int i = 0; i < P; i++) begin
                if ($urandom_range(0, 9) < 7)
                    r_dest[i*Q +: Q] = Q'(1) << $urandom_range(0, Q - 1);
                else
                    r_dest[i*Q +: Q] = Q'($urandom_range(0, 31));
                r_stb[i] = ($urandom_range(0, 9) != 0);
            end
            for (int o = 0; o < Q; o++) begin
                r_fail[o]   = ($urandom_range(0, 19) == 0);
                r_cancel[o] = ($urandom_range(0, 19) == 0);
            end
            drive(r_req, r_dest, r_stb, r_fail, r_cancel);
            check_model($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
